// File: rtl/str_pkg.sv
// Shared constants and helpers for the streaming FIFO: default value width
// and the pointer-width function used to size pointers and occupancy.
package str_pkg;

    localparam int STR_VW_DEFAULT    = 32;
    localparam int STR_DEPTH_DEFAULT = 4;

    // Ceiling log2 used for elaboration-time sizing; clog2(1) is 0.
    function automatic int clog2(input int n);
        int w;
        int v;
        w = 0;
        v = n - 1;
        while (v > 0) begin
            w = w + 1;
            v = v >> 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/str_fifo_mem.sv
// DEPTH x VW storage for str_fifo: one synchronous write port, one
// asynchronous read port. Contents are deliberately not reset.
module str_fifo_mem #(
    parameter int VW    = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [VW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [VW-1:0] rdata_o
);

    logic [VW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/str_fifo.sv
// Valid/ready streaming FIFO with registered ready/valid and fall-through read.
// Optional occupancy output port cnt is enabled by defining STR_FIFO_CNT_EN.
module str_fifo
    import str_pkg::*;
#(
    parameter int VW    = STR_VW_DEFAULT,
    parameter int DEPTH = STR_DEPTH_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sti_tvalid,
    output logic          sti_tready,
    input  logic [VW-1:0] sti_tvalue,
    output logic          sto_tvalid,
    input  logic          sto_tready,
    output logic [VW-1:0] sto_tvalue
`ifdef STR_FIFO_CNT_EN
    ,
    output logic [clog2(DEPTH):0] cnt
`endif
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   occ_q, occ_d;
    logic          sti_tready_q, sti_tready_d;
    logic          sto_tvalid_q, sto_tvalid_d;
    logic          push;
    logic          pop;

    always_comb begin
        push         = sti_tvalid & sti_tready_q;
        pop          = sto_tvalid_q & sto_tready;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        occ_d        = occ_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
        // Flags follow the next occupancy so they are exact in the cycle after the edge.
        sti_tready_d = (occ_d != OCC_FULL);
        sto_tvalid_d = (occ_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            sti_tready_q <= 1'b0;
            sto_tvalid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            sti_tready_q <= sti_tready_d;
            sto_tvalid_q <= sto_tvalid_d;
        end
    end

    str_fifo_mem #(
        .VW    (VW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (sti_tvalue),
        .raddr_i (rd_ptr_q),
        .rdata_o (sto_tvalue)
    );

    assign sti_tready = sti_tready_q;
    assign sto_tvalid = sto_tvalid_q;

`ifdef STR_FIFO_CNT_EN
    assign cnt = occ_q;
`endif

endmodule

// File: tb/tb_str_fifo.sv
// Directed and randomised bench for str_fifo against a queue scoreboard.
// Checks cnt as well when STR_FIFO_CNT_EN is defined.
module tb_str_fifo;

    localparam int VW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sti_tvalid = 1'b0;
    logic          sti_tready;
    logic [VW-1:0] sti_tvalue = '0;
    logic          sto_tvalid;
    logic          sto_tready = 1'b0;
    logic [VW-1:0] sto_tvalue;
`ifdef STR_FIFO_CNT_EN
    logic [2:0]    cnt;
`endif

    int            n_chk  = 0;
    int            n_fail = 0;
    logic [VW-1:0] model [$];
    logic [VW-1:0] last_pop = '0;
    bit            pushed;
    bit            popped;

    str_fifo #(.VW(VW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .sti_tvalid (sti_tvalid),
        .sti_tready (sti_tready),
        .sti_tvalue (sti_tvalue),
        .sto_tvalid (sto_tvalid),
        .sto_tready (sto_tready),
        .sto_tvalue (sto_tvalue)
`ifdef STR_FIFO_CNT_EN
        ,
        .cnt        (cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: score the handshakes seen before the edge, then check flags after it.
    task automatic cyc();
        pushed = sti_tvalid && sti_tready;
        popped = sto_tvalid && sto_tready;
        if (popped) begin
            if (model.size() == 0) begin
                chk("pop_on_empty", 64'(sto_tvalid), 64'(0));
            end else begin
                last_pop = sto_tvalue;
                chk("data", 64'(sto_tvalue), 64'(model.pop_front()));
            end
        end
        if (pushed) model.push_back(sti_tvalue);
        @(posedge clk);
        #1;
        chk("sti_tready", 64'(sti_tready), 64'(model.size() < DEPTH));
        chk("sto_tvalid", 64'(sto_tvalid), 64'(model.size() != 0));
`ifdef STR_FIFO_CNT_EN
        chk("cnt", 64'(cnt), 64'(model.size()));
`endif
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        sti_tvalid = 1'b0;
        sto_tready = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_ready", 64'(sti_tready), 64'(0));
        chk("rst_valid", 64'(sto_tvalid), 64'(0));
`ifdef STR_FIFO_CNT_EN
        chk("rst_cnt", 64'(cnt), 64'(0));
`endif
        rst = 1'b0;
        model.delete();
        @(posedge clk);
        #1;
        chk("post_rst_ready", 64'(sti_tready), 64'(1));
        chk("post_rst_valid", 64'(sto_tvalid), 64'(0));
`ifdef STR_FIFO_CNT_EN
        chk("post_rst_cnt", 64'(cnt), 64'(0));
`endif
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nxt;
        int delivered;
        int cycles;
        int stalls;

        // Reset then idle
        do_reset();
        cyc();
        cyc();

        // Single value held with drain stalled
        sti_tvalid = 1'b1;
        sti_tvalue = 32'hDEAD_BEEF;
        cyc();
        sti_tvalid = 1'b0;
        sti_tvalue = '0;
        chk("single_valid", 64'(sto_tvalid), 64'(1));
        for (int i = 0; i < 5; i++) begin
            chk("single_hold", 64'(sto_tvalue), 64'(32'hDEAD_BEEF));
            cyc();
        end
        sto_tready = 1'b1;
        cyc();
        sto_tready = 1'b0;
        chk("single_pop", 64'(last_pop), 64'(32'hDEAD_BEEF));
        chk("single_empty", 64'(sto_tvalid), 64'(0));

        // Fill to DEPTH, hold off a fifth value, pop once, accept it
        for (int i = 1; i <= 4; i++) begin
            sti_tvalid = 1'b1;
            sti_tvalue = 32'(i);
            cyc();
        end
        chk("fill_ready", 64'(sti_tready), 64'(0));
`ifdef STR_FIFO_CNT_EN
        chk("fill_cnt", 64'(cnt), 64'(4));
`endif
        sti_tvalue = 32'h99;
        cyc();
        chk("full_hold_off", 64'(pushed), 64'(0));
        sti_tvalue = 32'd5;
        cyc();
        sto_tready = 1'b1;
        cyc();
        sto_tready = 1'b0;
        chk("fill_pop1", 64'(last_pop), 64'(1));
        chk("ready_after_pop", 64'(sti_tready), 64'(1));
        cyc();
        chk("fifth_accepted", 64'(pushed), 64'(1));
        sti_tvalid = 1'b0;
        sto_tready = 1'b1;
        for (int k = 0; k < 10 && model.size() != 0; k++) cyc();
        sto_tready = 1'b0;
        chk("fill_last", 64'(last_pop), 64'(5));
        chk("fill_drained", 64'(sto_tvalid), 64'(0));

        // Streaming 0..99, both sides always willing
        nxt = 0; delivered = 0; cycles = 0; stalls = 0;
        sto_tready = 1'b1;
        while (delivered < 100 && cycles < 400) begin
            sti_tvalid = (nxt < 100);
            sti_tvalue = 32'(nxt);
            cyc();
            if (pushed) nxt++;
            if (popped) delivered++;
            if (cycles >= 1 && !popped) stalls++;
            cycles++;
        end
        sti_tvalid = 1'b0;
        sto_tready = 1'b0;
        chk("stream_count", 64'(delivered), 64'(100));
        chk("stream_cycles", 64'(cycles), 64'(101));
        chk("stream_stalls", 64'(stalls), 64'(0));
        chk("stream_last", 64'(last_pop), 64'(99));

        // Random valid/ready, 1000 values
        nxt = 0; delivered = 0; cycles = 0;
        while (delivered < 1000 && cycles < 20000) begin
            sti_tvalid = (nxt < 1000) && 1'($urandom_range(1));
            sti_tvalue = 32'(nxt) + 32'h1000;
            sto_tready = 1'($urandom_range(1));
            cyc();
            if (pushed) nxt++;
            if (popped) delivered++;
            cycles++;
        end
        sti_tvalid = 1'b0;
        sto_tready = 1'b0;
        chk("rand_count", 64'(delivered), 64'(1000));
        chk("rand_wraps", 64'(delivered / DEPTH >= 200), 64'(1));
        chk("rand_last", 64'(last_pop), 64'(32'h1000 + 999));

        // Reset with three entries stored
        for (int i = 0; i < 3; i++) begin
            sti_tvalid = 1'b1;
            sti_tvalue = 32'hA1 + 32'(i);
            cyc();
        end
        sti_tvalid = 1'b0;
`ifdef STR_FIFO_CNT_EN
        chk("pre_rst_cnt", 64'(cnt), 64'(3));
`endif
        do_reset();
        sti_tvalid = 1'b1;
        sti_tvalue = 32'h77;
        cyc();
        sti_tvalid = 1'b0;
        sto_tready = 1'b1;
        cyc();
        sto_tready = 1'b0;
        chk("after_rst_val", 64'(last_pop), 64'(32'h77));
        chk("after_rst_empty", 64'(sto_tvalid), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
